// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle multiply/divide unit with its own HI/LO pair.
//
// Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO (and optionally MADD/MADDU) for
// XLEN-bit operands. Multiply is a shift-add, divide is a restoring
// shift-subtract, both retiring one bit per cycle. Signed operations run on
// magnitudes and the signs are applied when the result is written.
//
// Optional feature macro: ALU_MULDIV_MADD_EN
//   defined   : MADD/MADDU accumulate the product into {hi,lo}
//   undefined : MADD/MADDU complete in one cycle with no HI/LO change
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op_valid/op_ready request handshake, accepted when both are high
//   op_code[2:0]      000 MULT 001 MULTU 010 DIV 011 DIVU
//                     100 MTHI 101 MTLO 110 MADD 111 MADDU
//   rs, rt            operand A / dividend / MT source, operand B / divisor
//   busy              operation in progress (RUN or FIN)
//   done              one-cycle pulse, hi/lo hold the new result
//   div_by_zero       with done: the divisor was zero
//   hi, lo            HI/LO registers
module alu_muldiv #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [2:0]      op_code,
   input  logic [XLEN-1:0] rs,
   input  logic [XLEN-1:0] rt,
   output logic            busy,
   output logic            done,
   output logic            div_by_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t state, state_nxt;

   // p_hi/p_lo hold {partial product, multiplier} for multiply and
   // {remainder, dividend/quotient} for divide; b_q is multiplicand/divisor.
   logic [XLEN-1:0]   p_hi, p_lo, b_q;
   logic [CNT_W-1:0]  cnt;
   logic              is_div_q, neg_res_q, neg_rem_q, dbz_q;
`ifdef ALU_MULDIV_MADD_EN
   logic              is_madd_q;
   logic [2*XLEN-1:0] mac;
`endif

   logic              accept;
   logic              op_is_div, op_is_mt, op_is_madd, op_signed, div_zero;
   logic              rs_neg, rt_neg;
   logic [XLEN-1:0]   rs_mag, rt_mag;
   logic [XLEN:0]     mul_sum, div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   step_hi, step_lo, quo, rem;
   logic [2*XLEN-1:0] prod, prod_s;

   // Request decode
   always_comb begin
      accept     = op_valid && (state == S_IDLE);
      op_is_div  = op_code[1] & ~op_code[2];
      op_is_mt   = op_code[2] & ~op_code[1];
      op_is_madd = op_code[2] &  op_code[1];
      op_signed  = ~op_code[0];
      div_zero   = op_is_div && (rt == '0);
      rs_neg     = op_signed & rs[XLEN-1];
      rt_neg     = op_signed & rt[XLEN-1];
      rs_mag     = rs_neg ? -rs : rs;
      rt_mag     = rt_neg ? -rt : rt;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (op_is_mt || div_zero) state_nxt = S_FIN;
`ifdef ALU_MULDIV_MADD_EN
               else if (op_is_madd)      state_nxt = S_RUN;
`else
               else if (op_is_madd)      state_nxt = S_FIN;
`endif
               else                      state_nxt = S_RUN;
            end
         end
         S_RUN:   if (cnt == CNT_W'(1)) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      op_ready    = (state == S_IDLE);
      busy        = (state == S_RUN) || (state == S_FIN);
      done        = (state == S_FIN);
      div_by_zero = (state == S_FIN) && dbz_q;
   end

   // One iteration step and signed result shaping
   always_comb begin
      mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_q} : '0);
      div_shift = {p_hi, p_lo[XLEN-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      if (is_div_q) begin
         step_hi = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
         step_lo = {p_lo[XLEN-2:0], div_ge};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], p_lo[XLEN-1:1]};
      end
      prod   = {step_hi, step_lo};
      prod_s = neg_res_q ? -prod : prod;
      quo    = neg_res_q ? -step_lo : step_lo;
      rem    = neg_rem_q ? -step_hi : step_hi;
`ifdef ALU_MULDIV_MADD_EN
      mac    = {hi, lo} + prod_s;
`endif
   end

   // Datapath and HI/LO; the final step result is written on the edge into FIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_hi      <= '0;
         p_lo      <= '0;
         b_q       <= '0;
         cnt       <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi        <= '0;
         lo        <= '0;
`ifdef ALU_MULDIV_MADD_EN
         is_madd_q <= 1'b0;
`endif
      end else if (accept) begin
         is_div_q  <= op_is_div;
         neg_res_q <= rs_neg ^ rt_neg;
         neg_rem_q <= rs_neg;
         dbz_q     <= div_zero;
         p_hi      <= '0;
         p_lo      <= rs_mag;
         b_q       <= rt_mag;
         cnt       <= CNT_W'(XLEN);
`ifdef ALU_MULDIV_MADD_EN
         is_madd_q <= op_is_madd;
`endif
         if (op_is_mt) begin
            if (op_code[0]) lo <= rs;
            else            hi <= rs;
         end
      end else if (state == S_RUN) begin
         p_hi <= step_hi;
         p_lo <= step_lo;
         cnt  <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            if (is_div_q)       {hi, lo} <= {rem, quo};
`ifdef ALU_MULDIV_MADD_EN
            else if (is_madd_q) {hi, lo} <= mac;
`endif
            else                {hi, lo} <= prod_s;
         end
      end
   end

endmodule
